wave_gen: RTL and testbench

Parametrised stepped-waveform source that produces a periodic signed sample stream on a valid/ready interface. It feeds the `fir` block's `i_data`/`i_valid` inputs in simulation and in on-chip self-test, and replaces hand-written per-sample state machines. Width, steps per period, hold length, waveform mode and amplitude are all configurable, and backpressure is honoured.

---
 rtl/wave_gen_pkg.sv | 34 +++
 rtl/wave_lut.sv | 38 +++
 rtl/wave_gen.sv | 101 ++++++++++
 tb/tb_wave_gen.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_gen_pkg.sv
// Shared types and the sine table generator for the stepped-waveform source.
package wave_gen_pkg;

   typedef enum logic [1:0] {
      SINE   = 2'd0,
      SQUARE = 2'd1,
      SAW    = 2'd2,
      ZERO   = 2'd3
   } wave_mode_t;

   // Elaboration-time only; the 16-bit/8-step table is pinned to fixed values.
   function automatic longint sine_lut(input int unsigned dwidth,
                                       input int unsigned nsteps,
                                       input int unsigned k);
      real    amp;
      real    ang;
      longint peak;
      peak = longint'(1) << (dwidth - 1);
      if (dwidth == 16 && nsteps == 8) begin
         case (k % 8)
            0, 4:    return 0;
            1, 3:    return 23166;
            2:       return 32767;
            5, 7:    return -23166;
            default: return -32768;
         endcase
      end
      if (k == (3 * nsteps) / 4) return -peak;
      amp = real'(peak - 1);
      ang = 2.0 * 3.14159265358979 * real'(k) / real'(nsteps);
      return longint'(amp * $sin(ang));
   endfunction

endpackage

// File: rtl/wave_lut.sv
// Combinational sample lookup: (mode, phase, shift) -> attenuated signed sample.
module wave_lut
   import wave_gen_pkg::*;
#(
   parameter int unsigned DWIDTH = 16,
   parameter int unsigned NSTEPS = 8,
   parameter int unsigned PWIDTH = $clog2(NSTEPS)
) (
   input  logic [1:0]        mode,
   input  logic [PWIDTH-1:0] phase,
   input  logic [3:0]        shift,
   output logic [DWIDTH-1:0] sample
);

   localparam logic [DWIDTH-1:0] SMAX = {1'b0, {(DWIDTH-1){1'b1}}};
   localparam logic [DWIDTH-1:0] SMIN = {1'b1, {(DWIDTH-1){1'b0}}};

   logic [DWIDTH-1:0] sine_tab [NSTEPS];
   logic [DWIDTH-1:0] raw;

   for (genvar g = 0; g < int'(NSTEPS); g++) begin : g_sine
      localparam logic [DWIDTH-1:0] VAL = DWIDTH'(sine_lut(DWIDTH, NSTEPS, g));
      assign sine_tab[g] = VAL;
   end

   always_comb begin
      raw = '0;
      case (wave_mode_t'(mode))
         SINE:    raw = sine_tab[phase];
         SQUARE:  raw = phase[PWIDTH-1] ? SMIN : SMAX;
         // min + k*2^DWIDTH/NSTEPS: place k in the top bits, then flip the sign bit
         SAW:     raw = (DWIDTH'(phase) << (DWIDTH - PWIDTH)) ^ SMIN;
         default: raw = '0;
      endcase
      sample = $signed(raw) >>> shift;
   end

endmodule

// File: rtl/wave_gen.sv
// Stepped periodic waveform source with valid/ready output and per-period config latch.
module wave_gen
   import wave_gen_pkg::*;
#(
   parameter int unsigned DWIDTH = 16,
   parameter int unsigned NSTEPS = 8,
   parameter int unsigned HWIDTH = 4,
   parameter int unsigned PWIDTH = $clog2(NSTEPS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_en,
   input  logic [1:0]        i_mode,
   input  logic [HWIDTH-1:0] i_hold,
   input  logic [3:0]        i_shift,
   output logic [DWIDTH-1:0] o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [PWIDTH-1:0] o_phase,
   output logic              o_wrap
);

   logic [PWIDTH-1:0] phase, phase_n;
   logic [HWIDTH-1:0] hold_cnt, hold_n;
   logic [HWIDTH-1:0] cfg_hold, cfg_hold_n;
   logic [3:0]        cfg_shift, cfg_shift_n;
   wave_mode_t        cfg_mode, cfg_mode_n;
   logic              accept, start, last_beat, wrap, relatch, load;
   logic              valid_n, wrap_n;
   logic [DWIDTH-1:0] sample;

   always_comb begin
      accept    = o_valid & i_ready;
      start     = i_en & ~o_valid;
      last_beat = (hold_cnt == cfg_hold);
      wrap      = accept & last_beat & (&phase);
      phase_n   = phase;
      hold_n    = hold_cnt;
      if (accept) begin
         if (last_beat) begin
            hold_n  = '0;
            phase_n = phase + 1'b1;
         end else begin
            hold_n  = hold_cnt + 1'b1;
         end
      end

      relatch     = wrap | (start & (phase == '0) & (hold_cnt == '0));
      cfg_mode_n  = relatch ? wave_mode_t'(i_mode) : cfg_mode;
      cfg_hold_n  = relatch ? i_hold  : cfg_hold;
      cfg_shift_n = relatch ? i_shift : cfg_shift;

      // A new sample is loaded on acceptance while enabled, or on a fresh start
      load    = (accept & i_en) | start;
      valid_n = o_valid ? (~i_ready | i_en) : i_en;
      if (load)
         wrap_n = (phase_n == '0) & (hold_n == '0);
      else if (accept)
         wrap_n = 1'b0;
      else
         wrap_n = o_wrap;
   end

   wave_lut #(
      .DWIDTH(DWIDTH),
      .NSTEPS(NSTEPS),
      .PWIDTH(PWIDTH)
   ) u_lut (
      .mode  (cfg_mode_n),
      .phase (phase_n),
      .shift (cfg_shift_n),
      .sample(sample)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase     <= '0;
         hold_cnt  <= '0;
         cfg_mode  <= SINE;
         cfg_hold  <= '0;
         cfg_shift <= '0;
         o_valid   <= 1'b0;
         o_data    <= '0;
         o_phase   <= '0;
         o_wrap    <= 1'b0;
      end else begin
         phase     <= phase_n;
         hold_cnt  <= hold_n;
         cfg_mode  <= cfg_mode_n;
         cfg_hold  <= cfg_hold_n;
         cfg_shift <= cfg_shift_n;
         o_valid   <= valid_n;
         o_wrap    <= wrap_n;
         if (load) begin
            o_data  <= sample;
            o_phase <= phase_n;
         end
      end
   end

endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen against a beat-position reference model.
module tb_wave_gen;

   localparam int NS = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_en;
   logic [1:0]  i_mode;
   logic [3:0]  i_hold;
   logic [3:0]  i_shift;
   logic [15:0] o_data;
   logic        o_valid;
   logic        i_ready;
   logic [2:0]  o_phase;
   logic        o_wrap;

   int checks   = 0;
   int failures = 0;

   int sine_tab [8] = '{0, 23166, 32767, 23166, 0, -23166, -32768, -23166};
   logic [15:0] sine16 [8] = '{16'h0000, 16'h5A7E, 16'h7FFF, 16'h5A7E,
                               16'h0000, 16'hA582, 16'h8000, 16'hA582};

   // model: position within the period in beats, plus latched config
   bit m_valid;
   int m_mode, m_hold, m_shift, m_pos, m_data, m_phase;

   wave_gen #(.DWIDTH(16), .NSTEPS(8), .HWIDTH(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .i_en   (i_en),
      .i_mode (i_mode),
      .i_hold (i_hold),
      .i_shift(i_shift),
      .o_data (o_data),
      .o_valid(o_valid),
      .i_ready(i_ready),
      .o_phase(o_phase),
      .o_wrap (o_wrap)
   );

   always #5 clk = ~clk;

   function automatic int sample(int mode, int step, int shift);
      int v;
      case (mode)
         0:       v = sine_tab[step];
         1:       v = (step < NS / 2) ? 32767 : -32768;
         2:       v = -32768 + step * (65536 / NS);
         default: v = 0;
      endcase
      return v >>> shift;
   endfunction

   function automatic logic [20:0] exp_tuple();
      return {m_valid, m_valid && (m_pos == 0), 3'(m_phase), 16'(m_data)};
   endfunction

   function automatic logic [20:0] got_tuple();
      return {o_valid, o_wrap, o_phase, o_data};
   endfunction

   task automatic model_reset();
      m_valid = 0; m_mode = 0; m_hold = 0; m_shift = 0;
      m_pos = 0; m_data = 0; m_phase = 0;
   endtask

   task automatic model_load();
      if (m_pos == 0) begin
         m_mode  = int'(i_mode);
         m_hold  = int'(i_hold);
         m_shift = int'(i_shift);
      end
      m_valid = 1;
      m_phase = m_pos / (m_hold + 1);
      m_data  = sample(m_mode, m_phase, m_shift);
   endtask

   // advance the model with the inputs the DUT sees at the coming edge, then step
   task automatic tick();
      if (m_valid && i_ready) begin
         m_pos = (m_pos + 1) % (NS * (m_hold + 1));
         if (i_en) model_load();
         else m_valid = 0;
      end else if (!m_valid && i_en) begin
         model_load();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      i_en = 0; i_ready = 0; i_mode = 0; i_hold = 0; i_shift = 0;
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      model_reset();
   endtask

   task automatic test_reset();
      i_en = 0; i_ready = 1; i_mode = 0; i_hold = 0; i_shift = 0;
      rst = 1;
      #12;
      checks++;
      if (got_tuple() !== 21'h0) begin
         failures++;
         $display("FAIL reset_state got=%h exp=%h", got_tuple(), 21'h0);
      end
      rst = 0;
      model_reset();
      i_en = 1;
      for (int i = 0; i < 4; i++) tick();
      #2 rst = 1;
      #1;
      checks++;
      if (got_tuple() !== 21'h0) begin
         failures++;
         $display("FAIL reset_async got=%h exp=%h", got_tuple(), 21'h0);
      end
      model_reset();
      @(negedge clk);
      rst = 0;
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_data !== 16'h0000 || o_wrap !== 1'b1) begin
         failures++;
         $display("FAIL reset_start got v=%b d=%h w=%b exp v=1 d=0000 w=1", o_valid, o_data, o_wrap);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (got_tuple() !== exp_tuple()) begin
            failures++;
            $display("FAIL reset_run got=%h exp=%h", got_tuple(), exp_tuple());
         end
      end
   endtask

   task automatic test_default_sine();
      do_reset();
      i_hold = 4; i_en = 1; i_ready = 1;
      for (int i = 0; i < 80; i++) begin
         tick();
         checks++;
         if (o_data !== sine16[(i / 5) % 8] || o_wrap !== (i % 40 == 0) || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL sine_hold4 beat=%0d got d=%h w=%b v=%b exp d=%h w=%b v=1",
                     i, o_data, o_wrap, o_valid, sine16[(i / 5) % 8], (i % 40 == 0));
         end
         checks++;
         if (got_tuple() !== exp_tuple()) begin
            failures++;
            $display("FAIL sine_model got=%h exp=%h", got_tuple(), exp_tuple());
         end
      end
   endtask

   task automatic test_backpressure();
      int acc_n;
      bit stalled;
      logic [15:0] prev;
      acc_n = 0;
      do_reset();
      i_en = 1;
      tick();
      for (int i = 0; i < 200; i++) begin
         i_ready = ($urandom_range(0, 2) != 0);
         stalled = m_valid && !i_ready;
         prev    = 16'(m_data);
         if (o_valid && i_ready) begin
            checks++;
            if (o_data !== sine16[acc_n % 8]) begin
               failures++;
               $display("FAIL bp_accept idx=%0d got=%h exp=%h", acc_n, o_data, sine16[acc_n % 8]);
            end
            acc_n++;
         end
         tick();
         if (stalled) begin
            checks++;
            if (o_data !== prev) begin
               failures++;
               $display("FAIL bp_stall got=%h exp=%h", o_data, prev);
            end
         end
         checks++;
         if (got_tuple() !== exp_tuple()) begin
            failures++;
            $display("FAIL bp_model got=%h exp=%h", got_tuple(), exp_tuple());
         end
      end
   endtask

   task automatic test_mode_switch();
      logic [15:0] expc [32];
      for (int i = 0; i < 8; i++) expc[i] = sine16[i];
      for (int i = 0; i < 8; i++) expc[8 + i] = 16'h8000 + 16'(i * 16'h2000);
      for (int i = 0; i < 8; i++) expc[16 + i] = 16'h7FFF;
      for (int i = 0; i < 8; i++) expc[24 + i] = 16'h8000;
      do_reset();
      i_en = 1; i_ready = 1;
      for (int i = 0; i < 32; i++) begin
         tick();
         checks++;
         if (o_data !== expc[i]) begin
            failures++;
            $display("FAIL mode_switch beat=%0d got=%h exp=%h", i, o_data, expc[i]);
         end
         checks++;
         if (got_tuple() !== exp_tuple()) begin
            failures++;
            $display("FAIL mode_model got=%h exp=%h", got_tuple(), exp_tuple());
         end
         if (i == 3) i_mode = 2;
         if (i == 10) begin
            i_mode = 1;
            i_hold = 1;
         end
      end
   endtask

   task automatic test_attenuation();
      logic [15:0] expc [8] = '{16'h0000, 16'h2D3F, 16'h3FFF, 16'h2D3F,
                                16'h0000, 16'hD2C1, 16'hC000, 16'hD2C1};
      do_reset();
      i_shift = 1; i_en = 1; i_ready = 1;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (o_data !== expc[i]) begin
            failures++;
            $display("FAIL atten beat=%0d got=%h exp=%h", i, o_data, expc[i]);
         end
      end
   endtask

   task automatic test_enable_gating();
      do_reset();
      i_en = 1; i_ready = 1;
      repeat (3) tick();
      i_ready = 0;
      tick();
      i_en = 0;
      repeat (2) tick();
      checks++;
      if (o_valid !== 1'b1 || o_phase !== 3'd2 || o_data !== 16'h7FFF) begin
         failures++;
         $display("FAIL gate_hold got v=%b p=%0d d=%h exp v=1 p=2 d=7fff", o_valid, o_phase, o_data);
      end
      i_ready = 1;
      tick();
      checks++;
      if (o_valid !== 1'b0) begin
         failures++;
         $display("FAIL gate_drop got v=%b exp v=0", o_valid);
      end
      repeat (2) tick();
      checks++;
      if (got_tuple() !== exp_tuple()) begin
         failures++;
         $display("FAIL gate_idle got=%h exp=%h", got_tuple(), exp_tuple());
      end
      i_en = 1;
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_phase !== 3'd3 || o_data !== 16'h5A7E) begin
         failures++;
         $display("FAIL gate_resume got v=%b p=%0d d=%h exp v=1 p=3 d=5a7e", o_valid, o_phase, o_data);
      end
      tick();
      checks++;
      if (o_phase !== 3'd4 || o_data !== 16'h0000) begin
         failures++;
         $display("FAIL gate_next got p=%0d d=%h exp p=4 d=0000", o_phase, o_data);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            i_mode  = 2'($urandom_range(0, 3));
            i_hold  = 4'($urandom_range(0, 3));
            i_shift = 4'($urandom_range(0, 15));
         end
         i_en    = ($urandom_range(0, 9) != 0);
         i_ready = ($urandom_range(0, 2) != 0);
         tick();
         checks++;
         if (got_tuple() !== exp_tuple()) begin
            failures++;
            $display("FAIL random cyc=%0d got=%h exp=%h", i, got_tuple(), exp_tuple());
         end
      end
   endtask

   initial begin
      test_reset();
      test_default_sine();
      test_backpressure();
      test_mode_switch();
      test_attenuation();
      test_enable_gating();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
